// File: rtl/wb_master_arb_if.sv
// Wishbone bundle between the initiators, the round-robin arbiter and the shared slave bus.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface wb_master_arb_if #(
  parameter int MASTERS = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
);
  logic [MASTERS-1:0]        m_cyc_i;
  logic [MASTERS-1:0]        m_stb_i;
  logic [MASTERS-1:0]        m_we_i;
  logic [MASTERS*AW-1:0]     m_adr_i;
  logic [MASTERS*DW-1:0]     m_dat_i;
  logic [MASTERS*DW/8-1:0]   m_sel_i;
  logic [MASTERS-1:0]        m_ack_o;
  logic [MASTERS-1:0]        m_err_o;
  logic [DW-1:0]             m_dat_o;
  logic                      s_cyc_o;
  logic                      s_stb_o;
  logic                      s_we_o;
  logic [AW-1:0]             s_adr_o;
  logic [DW-1:0]             s_dat_o;
  logic [DW/8-1:0]           s_sel_o;
  logic                      s_ack_i;
  logic [DW-1:0]             s_dat_i;

  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );
endinterface

// File: rtl/wb_master_arb.sv
// Round-robin Wishbone arbiter: grant held for a whole cyc, combinational pass-through of the
// owner onto the shared bus, and a watchdog that ends unanswered strobes with a one-cycle err.
module wb_master_arb #(
  parameter int MASTERS = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_master_arb_if.master   bus
);
  localparam int GW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = DW / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            found;
  logic [GW-1:0]   pick;
  int              idx;
  logic            busy;
  logic            own_cyc;
  logic            own_stb;
  logic            timeout_hit;
  logic [MASTERS-1:0] ack_vec;
  logic [MASTERS-1:0] err_vec;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(MASTERS - 1);
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  // Round-robin search starts just after the previous owner so nobody can be starved.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 1; i <= MASTERS; i++) begin
      idx = (int'(last_q) + i) % MASTERS;
      if (!found && bus.m_cyc_i[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  assign busy        = (state_q == BUSY);
  assign own_cyc     = bus.m_cyc_i[grant_q];
  assign own_stb     = bus.m_stb_i[grant_q];
  assign timeout_hit = busy && own_cyc && own_stb && !bus.s_ack_i &&
                       (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    timer_d = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          last_d  = grant_q;
          state_d = IDLE;
        end else if (own_stb && !bus.s_ack_i && !timeout_hit) begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared-bus drive: zeros while idle; the watchdog cycle suppresses the strobe.
  always_comb begin
    ack_vec = '0;
    err_vec = '0;
    if (busy) begin
      ack_vec[grant_q] = bus.s_ack_i & own_stb;
      err_vec[grant_q] = timeout_hit;
    end
  end

  assign bus.m_ack_o = ack_vec;
  assign bus.m_err_o = err_vec;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.s_cyc_o = busy;
  assign bus.s_stb_o = busy & own_stb & ~timeout_hit;
  assign bus.s_we_o  = busy & bus.m_we_i[grant_q];
  assign bus.s_adr_o = busy ? bus.m_adr_i[int'(grant_q)*AW +: AW] : '0;
  assign bus.s_dat_o = busy ? bus.m_dat_i[int'(grant_q)*DW +: DW] : '0;
  assign bus.s_sel_o = busy ? bus.m_sel_i[int'(grant_q)*SW +: SW] : '0;
endmodule
